prog_ctr_stack: RTL and testbench
=================================

Name: prog_ctr_stack

Overview:
Parametrised program counter for the sequencer front end. Drives the instruction ROM address and selects the next PC from one of several sources:
- sequential increment
- absolute jump
- signed relative branch
- subroutine call/return, through an internal return-address stack

It adds stall, a sticky fault flag and a programmable end-of-program address. The done/fault flags feed the top-level test harness.

Parameters:
PC_W, 10, PC / jump-target width in bits.
OFF_W, 8, width of signed two's-complement relative branch offset (OFF_W <= PC_W).
STACK_DEPTH, 4, return-address stack entries (>= 1).
DONE_ADDR, 2**PC_W-1, address whose sequential advance ends the program.

Ports:
Clk  in  1  system clock, all state updates on rising edge.
Reset  in  1  synchronous, active-high; clears all state.
Stall  in  1  hold PC and stack this cycle.
Jen  in  1  absolute jump request.
Jump  in  PC_W  absolute target for Jen and Call.
Ben  in  1  relative branch request.
Offset  in  OFF_W  signed branch offset, relative to current PC.
Call  in  1  push PC+1, go to Jump.
Ret  in  1  pop stack into PC.
PC  out  PC_W  current instruction address (registered).
pc_done_flag  out  1  program finished; sticky.
fault  out  1  stack overflow/underflow; sticky.
sp  out  clog2(STACK_DEPTH+1)  current stack occupancy.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. Reset has highest priority: PC=0, pc_done_flag=0, fault=0, sp=0, stack contents don't-care.
- Terminal state: pc_done_flag=1 freezes PC, sp and the stack until Reset. All requests are ignored.
- Next-state priority, when not reset and not done:
  1. Stall: hold everything.
  2. Ret
  3. Call
  4. Jen
  5. Ben
  6. Increment
- Only the highest-priority asserted request takes effect. Lower ones are dropped, not queued.
- Increment:
  - PC==DONE_ADDR: PC holds, pc_done_flag<=1.
  - Otherwise PC<=PC+1, modulo 2**PC_W.
- Jen: PC<=Jump. If Jump==0, also pc_done_flag<=1; PC still loads 0.
- Ben: PC<=PC+signext(Offset), truncated to PC_W (wraps both directions). Offset 0 is a self-loop. Ben never sets done.
- Call:
  - sp<STACK_DEPTH: stack[sp]<=PC+1 (mod 2**PC_W), sp<=sp+1, PC<=Jump.
  - sp==STACK_DEPTH: overflow. fault<=1, pc_done_flag<=1, PC/sp/stack hold.
- Ret:
  - sp>0: PC<=stack[sp-1], sp<=sp-1.
  - sp==0: underflow. fault<=1, pc_done_flag<=1, PC holds.
- Call with Jump==0 does not set done; only Jen does.
- Latency: every change is visible on PC the cycle after the edge that samples the request. There is no combinational path from inputs to PC, sp or the flags.
- Reset mid-operation, including during Stall or with requests asserted: the reset values win on that edge.
- Stall asserted in the same cycle as a fault-causing request: no fault (Stall wins).

Test Plan:
- Reset, then 5 idle cycles -> PC 0,1,2,3,4,5. pc_done_flag=0, sp=0. With DONE_ADDR=3: PC reaches 3 and holds; pc_done_flag=1 one cycle later, stays 1.
- PC=20, Ben=1 with Offset=8'hF6 (-10) -> PC=10. PC=1020 (PC_W=10), Offset=8 -> PC=4 (wrap), done=0.
- PC=5, Call with Jump=100 -> PC=100, sp=1. Ret -> PC=6, sp=0. Nested calls to depth 4, then 4 returns -> return addresses come back LIFO.
- Fill stack (sp=4), then Call -> fault=1, pc_done_flag=1, PC unchanged; subsequent Jen ignored. Separately, from Reset, Ret -> fault=1.
- Stall held 3 cycles with Jen=1, Jump=40 -> PC frozen throughout. Release Stall with Jen still set -> PC=40. Jen with Jump=0 -> PC=0, pc_done_flag=1.
- Simultaneous Ret+Call+Jen with sp=1 -> Ret taken only. Reset asserted with Call active -> PC=0, sp=0, flags 0 next cycle.

Source files
------------

// File: rtl/prog_ctr_stack_if.sv
// rtl/prog_ctr_stack_if.sv - request/status bundle between sequencer and program counter
interface prog_ctr_stack_if #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 8,
   parameter int SP_W  = 3
);
   logic             Stall;
   logic             Jen;
   logic [PC_W-1:0]  Jump;
   logic             Ben;
   logic [OFF_W-1:0] Offset;
   logic             Call;
   logic             Ret;
   logic [PC_W-1:0]  PC;
   logic             pc_done_flag;
   logic             fault;
   logic [SP_W-1:0]  sp;

   modport master (
      output Stall, Jen, Jump, Ben, Offset, Call, Ret,
      input  PC, pc_done_flag, fault, sp
   );

   modport slave (
      input  Stall, Jen, Jump, Ben, Offset, Call, Ret,
      output PC, pc_done_flag, fault, sp
   );
endinterface

// File: rtl/prog_ctr_stack.sv
// rtl/prog_ctr_stack.sv - program counter with jump, relative branch and call/return stack
module prog_ctr_stack #(
   parameter int          PC_W        = 10,
   parameter int          OFF_W       = 8,
   parameter int          STACK_DEPTH = 4,
   parameter int unsigned DONE_ADDR   = 2**PC_W - 1
) (
   input logic              Clk,
   input logic              Reset,
   prog_ctr_stack_if.slave  bus
);
   localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
   localparam logic [PC_W-1:0] DONE_PC = PC_W'(DONE_ADDR);
   localparam logic [SP_W-1:0] FULL_SP = SP_W'(STACK_DEPTH);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            done_q, done_d;
   logic            fault_q, fault_d;
   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [PC_W-1:0] stack_d [STACK_DEPTH];

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] stack_top;

   always_comb begin
      pc_inc    = pc_q + PC_W'(1);
      off_ext   = PC_W'($signed(bus.Offset));
      stack_top = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) stack_top = stack_q[i];
      end
   end

   // Priority chain: only the highest asserted request acts; done freezes everything.
   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      done_d  = done_q;
      fault_d = fault_q;
      stack_d = stack_q;
      if (!done_q && !bus.Stall) begin
         if (bus.Ret) begin
            if (sp_q != '0) begin
               pc_d = stack_top;
               sp_d = sp_q - SP_W'(1);
            end else begin
               fault_d = 1'b1;
               done_d  = 1'b1;
            end
         end else if (bus.Call) begin
            if (sp_q < FULL_SP) begin
               for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
               end
               sp_d = sp_q + SP_W'(1);
               pc_d = bus.Jump;
            end else begin
               fault_d = 1'b1;
               done_d  = 1'b1;
            end
         end else if (bus.Jen) begin
            pc_d = bus.Jump;
            if (bus.Jump == '0) done_d = 1'b1;
         end else if (bus.Ben) begin
            pc_d = pc_q + off_ext;
         end else if (pc_q == DONE_PC) begin
            done_d = 1'b1;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q    <= '0;
         sp_q    <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   // Stack contents are don't-care after reset; sp alone defines validity.
   always_ff @(posedge Clk) begin
      stack_q <= stack_d;
   end

   assign bus.PC           = pc_q;
   assign bus.sp           = sp_q;
   assign bus.pc_done_flag = done_q;
   assign bus.fault        = fault_q;
endmodule

// File: tb/tb_prog_ctr_stack.sv
// tb/tb_prog_ctr_stack.sv - directed self-checking bench for prog_ctr_stack
module tb_prog_ctr_stack;
   logic Clk = 1'b0;
   logic Reset;
   logic Reset2;
   int   n_cmp  = 0;
   int   n_fail = 0;

   prog_ctr_stack_if #(.PC_W(10), .OFF_W(8), .SP_W(3)) bus ();
   prog_ctr_stack_if #(.PC_W(10), .OFF_W(8), .SP_W(3)) bus2 ();

   prog_ctr_stack dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   prog_ctr_stack #(.DONE_ADDR(3)) dut_d (.Clk(Clk), .Reset(Reset2), .bus(bus2));

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input int st, input int ret, input int call, input int jen,
                        input int ben, input int jump, input int off);
      bus.Stall  = 1'(st);
      bus.Ret    = 1'(ret);
      bus.Call   = 1'(call);
      bus.Jen    = 1'(jen);
      bus.Ben    = 1'(ben);
      bus.Jump   = 10'(jump);
      bus.Offset = 8'(off);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   // vector fields: stall ret call jen ben jump off | pc sp done fault
   task automatic test_reset();
      drive(0, 0, 1, 1, 0, 55, 0);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (integer'(bus.PC) !== 0 || integer'(bus.sp) !== 0 ||
          bus.pc_done_flag !== 1'b0 || bus.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset pc=%0d sp=%0d done=%b fault=%b, expected pc=0 sp=0 done=0 fault=0",
                  bus.PC, bus.sp, bus.pc_done_flag, bus.fault);
      end
   endtask

   task automatic test_increment();
      int v [5][11] = '{
         '{0,0,0,0,0,0,0, 1,0,0,0},
         '{0,0,0,0,0,0,0, 2,0,0,0},
         '{0,0,0,0,0,0,0, 3,0,0,0},
         '{0,0,0,0,0,0,0, 4,0,0,0},
         '{0,0,0,0,0,0,0, 5,0,0,0}};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL increment[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_done_addr();
      int e_pc   [6] = '{1, 2, 3, 3, 3, 3};
      int e_done [6] = '{0, 0, 0, 1, 1, 1};
      bus2.Stall = 1'b0; bus2.Ret = 1'b0; bus2.Call = 1'b0; bus2.Jen = 1'b0;
      bus2.Ben = 1'b0; bus2.Jump = '0; bus2.Offset = '0;
      Reset2 = 1'b1;
      step();
      Reset2 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            bus2.Jen  = 1'b1;
            bus2.Jump = 10'd9;
         end
         step();
         n_cmp++;
         if (integer'(bus2.PC) !== e_pc[i] || integer'(bus2.pc_done_flag) !== e_done[i] ||
             bus2.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL done_addr[%0d] pc=%0d done=%b fault=%b, expected pc=%0d done=%0d fault=0",
                     i, bus2.PC, bus2.pc_done_flag, bus2.fault, e_pc[i], e_done[i]);
         end
      end
      bus2.Jen = 1'b0;
   endtask

   task automatic test_branch();
      int v [10][11] = '{
         '{0,0,0,1,0,  20,  0,   20,0,0,0},
         '{0,0,0,0,1,   0,'hF6,  10,0,0,0},
         '{0,0,0,1,0,1020,  0, 1020,0,0,0},
         '{0,0,0,0,1,   0,  8,    4,0,0,0},
         '{0,0,0,0,1,   0,  0,    4,0,0,0},
         '{0,0,0,0,1,   0,'h80, 900,0,0,0},
         '{0,0,0,1,0,1020,  0, 1020,0,0,0},
         '{0,0,0,0,1,   0,  3, 1023,0,0,0},
         '{0,0,0,0,0,   0,  0, 1023,0,1,0},
         '{0,0,0,0,1,   0,  5, 1023,0,1,0}};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL branch[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_call_ret();
      int v [13][11] = '{
         '{0,0,0,1,0,  5,0,   5,0,0,0},
         '{0,0,1,0,0,100,0, 100,1,0,0},
         '{0,1,0,0,0,  0,0,   6,0,0,0},
         '{0,0,1,0,0,200,0, 200,1,0,0},
         '{0,0,1,0,0,300,0, 300,2,0,0},
         '{0,0,1,0,0,400,0, 400,3,0,0},
         '{0,0,1,0,0,500,0, 500,4,0,0},
         '{0,1,0,0,0,  0,0, 401,3,0,0},
         '{0,1,0,0,0,  0,0, 301,2,0,0},
         '{0,1,0,0,0,  0,0, 201,1,0,0},
         '{0,1,0,0,0,  0,0,   7,0,0,0},
         '{0,0,1,0,0,  0,0,   0,1,0,0},
         '{0,1,0,0,0,  0,0,   8,0,0,0}};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL call_ret[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_overflow();
      int v [7][11] = '{
         '{0,0,1,0,0,10,0, 10,1,0,0},
         '{0,0,1,0,0,20,0, 20,2,0,0},
         '{0,0,1,0,0,30,0, 30,3,0,0},
         '{0,0,1,0,0,40,0, 40,4,0,0},
         '{0,0,1,0,0,50,0, 40,4,1,1},
         '{0,0,0,1,0,77,0, 40,4,1,1},
         '{0,1,0,0,0, 0,0, 40,4,1,1}};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL overflow[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_underflow();
      int v [3][11] = '{
         '{1,1,0,0,0,0,0, 0,0,0,0},
         '{0,1,0,0,0,0,0, 0,0,1,1},
         '{0,0,0,0,0,0,0, 0,0,1,1}};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL underflow[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_stall();
      int v [7][11] = '{
         '{0,0,0,0,0, 0,0,  1,0,0,0},
         '{1,0,0,1,0,40,0,  1,0,0,0},
         '{1,0,0,1,0,40,0,  1,0,0,0},
         '{1,0,0,1,0,40,0,  1,0,0,0},
         '{0,0,0,1,0,40,0, 40,0,0,0},
         '{0,0,0,1,0, 0,0,  0,0,1,0},
         '{0,0,0,0,0, 0,0,  0,0,1,0}};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL stall[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_priority();
      int v [4][11] = '{
         '{0,0,1,0,0,100,0, 100,1,0,0},
         '{0,1,1,1,0,333,0,   1,0,0,0},
         '{0,0,1,1,1, 50,3,  50,1,0,0},
         '{0,0,0,1,1, 60,3,  60,1,0,0}};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6]);
         step();
         n_cmp++;
         if (integer'(bus.PC) !== v[i][7] || integer'(bus.sp) !== v[i][8] ||
             integer'(bus.pc_done_flag) !== v[i][9] || integer'(bus.fault) !== v[i][10]) begin
            n_fail++;
            $display("FAIL priority[%0d] pc=%0d sp=%0d done=%b fault=%b, expected pc=%0d sp=%0d done=%0d fault=%0d",
                     i, bus.PC, bus.sp, bus.pc_done_flag, bus.fault, v[i][7], v[i][8], v[i][9], v[i][10]);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 1, 0, 0, 70, 0);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_cmp++;
      if (integer'(bus.PC) !== 0 || integer'(bus.sp) !== 0 ||
          bus.pc_done_flag !== 1'b0 || bus.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid pc=%0d sp=%0d done=%b fault=%b, expected pc=0 sp=0 done=0 fault=0",
                  bus.PC, bus.sp, bus.pc_done_flag, bus.fault);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      n_cmp++;
      if (integer'(bus.PC) !== 1 || integer'(bus.sp) !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_resume pc=%0d sp=%0d, expected pc=1 sp=0", bus.PC, bus.sp);
      end
   endtask

   initial begin
      Reset  = 1'b1;
      Reset2 = 1'b1;
      bus2.Stall = 1'b0; bus2.Ret = 1'b0; bus2.Call = 1'b0; bus2.Jen = 1'b0;
      bus2.Ben = 1'b0; bus2.Jump = '0; bus2.Offset = '0;
      test_reset();
      test_increment();
      test_done_addr();
      test_branch();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_stall();
      test_priority();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
